// File: rtl/frame_loader.sv
// Purpose : collects host pixel bytes into 32-bit {8'h00,R,G,B} words and pushes them, one per
//           pixel, into the SDRAM write FIFO at consecutive word addresses for N slideshow frames.
// Latency : oWRITE_EN asserts the cycle after the last byte of a pixel is accepted (if not full).
// Backpressure: oBYTE_READY drops while a pixel waits for the FIFO; iWRITE_FULL stalls the push.
//
// Ports:
//   iCLK, iRST_n          clock, asynchronous active-low reset
//   iSTART, iNUM_FRAMES   single-cycle load request and frame count (0 means 1)
//   iBYTE, iBYTE_VALID,
//   oBYTE_READY           host byte stream, valid/ready handshake
//   oWRITE_DATA, oWRITE_EN,
//   oWRITE_ADDR, iWRITE_FULL  SDRAM write-FIFO push side
//   oLoading, oDone, oFrameIdx  status to the display controller
//
// Build option: define RGB565_EN for 2-byte RGB565 pixels (high byte first) expanded to RGB888;
// otherwise pixels are 3 bytes in order R, G, B.
module frame_loader #(
    parameter int FRAME_WORDS = 384000,
    parameter int MAX_FRAMES  = 16
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iSTART,
    input  logic [3:0]  iNUM_FRAMES,
    input  logic [7:0]  iBYTE,
    input  logic        iBYTE_VALID,
    output logic        oBYTE_READY,
    output logic [31:0] oWRITE_DATA,
    output logic        oWRITE_EN,
    input  logic        iWRITE_FULL,
    output logic [22:0] oWRITE_ADDR,
    output logic        oLoading,
    output logic        oDone,
    output logic [3:0]  oFrameIdx
);

    localparam int PIX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

`ifdef RGB565_EN
    localparam logic [1:0] LAST_BYTE = 2'd1;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PIX_W-1:0] pixel_cnt;
    logic [3:0]       frame_idx;
    logic [4:0]       frames_total;
    logic [4:0]       start_frames;
    logic [1:0]       byte_cnt;
    logic [7:0]       byte0;
`ifndef RGB565_EN
    logic [7:0]       byte1;
`endif
    logic [22:0]      addr;
    logic [31:0]      wr_data;
    logic [31:0]      pix_word;

    logic accept;
    logic push;
    logic frame_end;
    logic last_pixel;

    assign accept     = (state == COLLECT) && iBYTE_VALID;
    assign push       = (state == WRITE) && !iWRITE_FULL;
    assign frame_end  = (pixel_cnt == PIX_W'(FRAME_WORDS - 1));
    assign last_pixel = frame_end && ({1'b0, frame_idx} == (frames_total - 5'd1));

    // Frame count actually loaded: 0 requests one frame, and never more than the slideshow holds.
    always_comb begin
        start_frames = (iNUM_FRAMES == 4'd0) ? 5'd1 : {1'b0, iNUM_FRAMES};
        if (int'(start_frames) > MAX_FRAMES) begin
            start_frames = 5'(MAX_FRAMES);
        end
    end

    // Assemble the pixel word from the stored bytes plus the byte being accepted now.
`ifdef RGB565_EN
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    always_comb begin
        r5       = byte0[7:3];
        g6       = {byte0[2:0], iBYTE[7:5]};
        b5       = iBYTE[4:0];
        // Replicate the top bits into the low bits so full-scale maps to 8'hFF.
        pix_word = {8'h00, r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    end
`else
    assign pix_word = {8'h00, byte0, byte1, iBYTE};
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        oBYTE_READY = 1'b0;
        oWRITE_EN   = 1'b0;
        oLoading    = 1'b0;
        oDone       = 1'b0;
        case (state)
            IDLE: begin
                if (iSTART) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                oBYTE_READY = 1'b1;
                oLoading    = 1'b1;
                if (accept && (byte_cnt == LAST_BYTE)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                oLoading  = 1'b1;
                oWRITE_EN = push;
                if (push) begin
                    state_nxt = last_pixel ? DONE : COLLECT;
                end
            end
            DONE: begin
                oDone     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frames are stored back to back, so frame_idx*FRAME_WORDS + pixel_cnt is simply a running
    // word counter; keeping it as a counter avoids a wide multiplier in the address path.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pixel_cnt    <= '0;
            frame_idx    <= '0;
            frames_total <= '0;
            byte_cnt     <= '0;
            byte0        <= '0;
`ifndef RGB565_EN
            byte1        <= '0;
`endif
            addr         <= '0;
            wr_data      <= '0;
        end else begin
            if ((state == IDLE) && iSTART) begin
                frames_total <= start_frames;
                pixel_cnt    <= '0;
                frame_idx    <= '0;
                byte_cnt     <= '0;
                addr         <= '0;
            end
            if (accept) begin
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                    wr_data  <= pix_word;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
                if (byte_cnt == 2'd0) begin
                    byte0 <= iBYTE;
                end
`ifndef RGB565_EN
                if (byte_cnt == 2'd1) begin
                    byte1 <= iBYTE;
                end
`endif
            end
            if (push) begin
                addr <= addr + 23'd1;
                if (frame_end) begin
                    pixel_cnt <= '0;
                    frame_idx <= frame_idx + 4'd1;
                end else begin
                    pixel_cnt <= pixel_cnt + 1'b1;
                end
            end
        end
    end

    assign oWRITE_DATA = wr_data;
    assign oWRITE_ADDR = addr;
    assign oFrameIdx   = frame_idx;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader with FRAME_WORDS=4: a byte/pixel-level reference model predicts every
// cycle's handshake and status outputs and the word/address of each push; directed sections pin
// the literal scenarios (first pixel, FIFO stall, two frames, mid-pixel reset, ignored restart).
module tb_frame_loader;

    localparam int FW = 4;
`ifdef RGB565_EN
    localparam int BPP = 2;
`else
    localparam int BPP = 3;
`endif

    logic        iCLK;
    logic        iRST_n;
    logic        iSTART;
    logic [3:0]  iNUM_FRAMES;
    logic [7:0]  iBYTE;
    logic        iBYTE_VALID;
    logic        oBYTE_READY;
    logic [31:0] oWRITE_DATA;
    logic        oWRITE_EN;
    logic        iWRITE_FULL;
    logic [22:0] oWRITE_ADDR;
    logic        oLoading;
    logic        oDone;
    logic [3:0]  oFrameIdx;

    frame_loader #(.FRAME_WORDS(FW), .MAX_FRAMES(16)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iNUM_FRAMES(iNUM_FRAMES),
        .iBYTE(iBYTE), .iBYTE_VALID(iBYTE_VALID), .oBYTE_READY(oBYTE_READY),
        .oWRITE_DATA(oWRITE_DATA), .oWRITE_EN(oWRITE_EN), .iWRITE_FULL(iWRITE_FULL),
        .oWRITE_ADDR(oWRITE_ADDR), .oLoading(oLoading), .oDone(oDone), .oFrameIdx(oFrameIdx)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int push_count = 0;
    int done_count = 0;
    bit gaps = 0;
    bit full_rand = 0;

    // Reference model state
    bit          m_loading;
    bit          m_pix_ready;
    bit          m_done;
    int          m_have;
    int          m_frames;
    int          m_pushed;
    logic [7:0]  m_b [0:2];
    logic [31:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2);
`ifdef RGB565_EN
        int r, g, b;
        r = int'(b0) / 8;
        g = (int'(b0) % 8) * 8 + int'(b1) / 32;
        b = int'(b1) % 32;
        model_word = {8'h00, 8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
        if (b2 === 8'hxx) model_word = 32'hx;
`else
        model_word = {8'h00, b0, b1, b2};
`endif
    endfunction

    task automatic mdl_reset();
        m_loading   = 0;
        m_pix_ready = 0;
        m_done      = 0;
        m_have      = 0;
        m_pushed    = 0;
        m_frames    = 0;
    endtask

    // Compare-and-advance: outputs are checked mid-cycle, then the model absorbs the inputs that
    // the DUT will sample on the coming rising edge.
    initial begin
        bit exp_we;
        forever begin
            @(negedge iCLK);
            if (!iRST_n) continue;
            exp_we = m_pix_ready && !iWRITE_FULL;
            chk("byte_ready", oBYTE_READY, m_loading && !m_pix_ready);
            chk("write_en", oWRITE_EN, exp_we);
            chk("loading", oLoading, m_loading);
            chk("done", oDone, m_done);
            chk("frame_idx", oFrameIdx, 32'(m_pushed / FW));
            if (exp_we && oWRITE_EN) begin
                chk("write_data", oWRITE_DATA, m_word);
                chk("write_addr", oWRITE_ADDR, 32'(m_pushed));
            end
            if (oWRITE_EN) push_count++;
            if (oDone) done_count++;

            if (m_done) begin
                m_done = 0;
            end else if (!m_loading) begin
                if (iSTART) begin
                    m_loading = 1;
                    m_frames  = (iNUM_FRAMES == 0) ? 1 : int'(iNUM_FRAMES);
                    m_pushed  = 0;
                    m_have    = 0;
                end
            end else if (m_pix_ready) begin
                if (!iWRITE_FULL) begin
                    m_pushed++;
                    m_pix_ready = 0;
                    if (m_pushed == m_frames * FW) begin
                        m_loading = 0;
                        m_done    = 1;
                    end
                end
            end else if (iBYTE_VALID) begin
                m_b[m_have] = iBYTE;
                m_have++;
                if (m_have == BPP) begin
                    m_word      = model_word(m_b[0], m_b[1], (BPP == 3) ? m_b[2] : 8'h00);
                    m_pix_ready = 1;
                    m_have      = 0;
                end
            end
        end
    end

    // Random FIFO-full pressure, driven away from the point where the sequencer changes inputs.
    initial begin
        forever begin
            @(posedge iCLK);
            #2;
            if (full_rand) iWRITE_FULL = 1'($urandom % 2);
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic start(input logic [3:0] nf);
        iNUM_FRAMES = nf;
        iSTART      = 1'b1;
        step();
        iSTART      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        iBYTE       = b;
        iBYTE_VALID = 1'b1;
        acc = 0;
        n   = 0;
        while (!acc && n < 300) begin
            @(negedge iCLK);
            acc = oBYTE_READY;
            step();
            n++;
        end
        chk("byte_accepted", 32'(acc), 32'd1);
        iBYTE_VALID = 1'b0;
        iBYTE       = 8'($urandom);
        if (gaps && ($urandom % 3 == 0)) step();
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
    endtask

    task automatic wait_done();
        bit seen;
        int n;
        seen = 0;
        n    = 0;
        while (!seen && n < 1000) begin
            @(negedge iCLK);
            seen = oDone;
            n++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        step();
    endtask

    task automatic run(input logic [3:0] nf);
        start(nf);
        send_bytes(((nf == 0) ? 1 : int'(nf)) * FW * BPP);
        wait_done();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, oBYTE_READY, 0);
        chk({tag, "_we"}, oWRITE_EN, 0);
        chk({tag, "_loading"}, oLoading, 0);
        chk({tag, "_done"}, oDone, 0);
        chk({tag, "_fidx"}, oFrameIdx, 0);
        chk({tag, "_addr"}, oWRITE_ADDR, 0);
        chk({tag, "_data"}, oWRITE_DATA, 0);
    endtask

    task automatic reset_mid();
        #3;
        iRST_n = 1'b0;
        mdl_reset();
        #1;
        chk_all_zero("midreset");
        @(negedge iCLK);
        #2;
        iRST_n = 1'b1;
        step();
    endtask

    logic [7:0]  first_px [0:2];
    logic [31:0] first_exp;
    int pc0, dc0;

    initial begin
        iRST_n = 1'b0; iSTART = 0; iNUM_FRAMES = 0; iBYTE = 0; iBYTE_VALID = 0; iWRITE_FULL = 0;
        mdl_reset();
`ifdef RGB565_EN
        first_px[0] = 8'hF8; first_px[1] = 8'h1F; first_px[2] = 8'h00;
        first_exp   = 32'h00FF00FF;
`else
        first_px[0] = 8'h12; first_px[1] = 8'h34; first_px[2] = 8'h56;
        first_exp   = 32'h00123456;
`endif
        #12;
        chk_all_zero("reset");
        @(negedge iCLK);
        #2;
        iRST_n = 1'b1;
        step();

        // First pixel: push one cycle after the final byte, address 0.
        start(4'd1);
        for (int i = 0; i < BPP; i++) send_byte(first_px[i]);
        chk("first_we", oWRITE_EN, 1);
        chk("first_data", oWRITE_DATA, first_exp);
        chk("first_addr", oWRITE_ADDR, 0);
        chk("first_loading", oLoading, 1);
        send_bytes((FW - 1) * BPP);
        wait_done();

        // FIFO full for 5 cycles after the last byte of a pixel.
        start(4'd1);
        send_bytes(BPP - 1);
        iWRITE_FULL = 1'b1;
        send_byte(8'($urandom));
        for (int i = 0; i < 5; i++) begin
            chk("stall_we", oWRITE_EN, 0);
            chk("stall_ready", oBYTE_READY, 0);
            step();
        end
        iWRITE_FULL = 1'b0;
        #1;
        chk("release_we", oWRITE_EN, 1);
        pc0 = push_count;
        step();
        chk("release_we_next", oWRITE_EN, 0);
        chk("release_ready", oBYTE_READY, 1);
        chk("release_single_push", 32'(push_count - pc0), 1);
        send_bytes((FW - 1) * BPP);
        wait_done();

        // Two frames with random gaps and FIFO pressure.
        gaps = 1; full_rand = 1;
        pc0 = push_count; dc0 = done_count;
        run(4'd2);
        full_rand = 0; iWRITE_FULL = 1'b0;
        chk("two_frame_pushes", 32'(push_count - dc0 * 0 - pc0), 2 * FW);
        chk("two_frame_done", 32'(done_count - dc0), 1);
        chk("two_frame_loading", oLoading, 0);
        chk("two_frame_fidx", oFrameIdx, 2);

        // iNUM_FRAMES=0 loads one frame; a restart during collection is ignored.
        gaps = 0; full_rand = 1;
        pc0 = push_count; dc0 = done_count;
        start(4'd0);
        send_byte(8'($urandom));
        iNUM_FRAMES = 4'd5;
        iSTART = 1'b1;
        send_byte(8'($urandom));
        iSTART = 1'b0;
        send_bytes(FW * BPP - 2);
        wait_done();
        full_rand = 0; iWRITE_FULL = 1'b0;
        chk("restart_pushes", 32'(push_count - pc0), FW);
        chk("restart_done", 32'(done_count - dc0), 1);

        // Reset in the middle of a pixel, then reload from address 0.
        start(4'd1);
        send_bytes(BPP - 1);
        reset_mid();
        pc0 = push_count;
        run(4'd1);
        chk("after_reset_pushes", 32'(push_count - pc0), FW);

        // Randomised loads with stray valid bytes while idle.
        for (int it = 0; it < 6; it++) begin
            gaps = 1'($urandom % 2);
            full_rand = 1'($urandom % 2);
            iBYTE_VALID = 1'b1;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                iBYTE = 8'($urandom);
                step();
            end
            iBYTE_VALID = 1'b0;
            run(4'($urandom_range(0, 3)));
            full_rand = 0; iWRITE_FULL = 1'b0;
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 384000, meaning pixels per frame (800 x 480).
REQ-002 SHALL have parameter MAX_FRAMES, default 16, meaning slideshow frame capacity.
REQ-003 SHALL have port iCLK  in  1  system clock.
REQ-004 SHALL have port iRST_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port iSTART  in  1  single-cycle request to begin loading.
REQ-006 SHALL have port iNUM_FRAMES  in  4  number of frames to load; 0 treated as 1.
REQ-007 SHALL have port iBYTE  in  8  host pixel byte.
REQ-008 SHALL have port iBYTE_VALID  in  1  iBYTE valid.
REQ-009 SHALL have port oBYTE_READY  out  1  loader can accept a byte.
REQ-010 SHALL have port oWRITE_DATA  out  32  SDRAM word {8'h00,R,G,B}.
REQ-011 SHALL have port oWRITE_EN  out  1  single-cycle SDRAM write-FIFO push.
REQ-012 SHALL have port iWRITE_FULL  in  1  SDRAM write FIFO full.
REQ-013 SHALL have port oWRITE_ADDR  out  23  word address of oWRITE_DATA.
REQ-014 SHALL have port oLoading  out  1  loading in progress; drives the display controller iLoading.
REQ-015 SHALL have port oDone  out  1  single-cycle pulse when all frames are written.
REQ-016 SHALL have port oFrameIdx  out  4  index of the frame currently being loaded.

Function
REQ-017 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: iSTART=1 SHALL latch iNUM_FRAMES, clear pixel, byte and frame counters, and go to COLLECT; iSTART SHALL be ignored in every other state.
REQ-019 COLLECT: oBYTE_READY SHALL be 1; a byte is accepted only on a cycle with iBYTE_VALID=1 and oBYTE_READY=1.
REQ-020 Without RGB565_EN, bytes SHALL be taken in order R, G, B; acceptance of the third byte SHALL move the state to WRITE on the next cycle.
REQ-021 WRITE: oBYTE_READY SHALL be 0; oWRITE_EN SHALL pulse for exactly one cycle, on the first cycle with iWRITE_FULL=0; while iWRITE_FULL=1 the state SHALL hold, with no data or address change.
REQ-022 Latency: if iWRITE_FULL=0, oWRITE_EN SHALL assert exactly one cycle after the final byte of a pixel is accepted.
REQ-023 oWRITE_ADDR SHALL equal frame_idx*FRAME_WORDS + pixel_cnt, computed without truncation in 23 bits.
REQ-024 After each push, pixel_cnt SHALL increment; at FRAME_WORDS-1 it SHALL wrap to 0 and oFrameIdx SHALL increment.
REQ-025 After a push, the state SHALL go to DONE if the last pixel of the last latched frame was written, otherwise to COLLECT.
REQ-026 DONE: oDone SHALL be 1 for one cycle, oLoading SHALL fall, and the state SHALL return to IDLE next cycle.
REQ-027 oLoading SHALL be 1 from the cycle after iSTART is accepted until DONE, inclusive of COLLECT and WRITE.
REQ-028 iBYTE_VALID in IDLE, WRITE or DONE SHALL be ignored; no byte SHALL be lost or double-counted.

Reset
REQ-029 Asserting iRST_n=0 at any time, including mid-pixel or mid-frame, SHALL immediately force IDLE and set oBYTE_READY, oWRITE_EN, oLoading, oDone, oFrameIdx, oWRITE_ADDR and oWRITE_DATA to 0.
REQ-030 Partially collected pixel bytes SHALL be discarded on reset; loading restarts only on a new iSTART.

Configuration
REQ-031 With macro RGB565_EN defined, each pixel SHALL be 2 bytes (high byte first, RGB565), expanded as R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}; without it, each pixel SHALL be 3 bytes R, G, B as in REQ-020.

Verification
REQ-032 Reset, then iSTART with iNUM_FRAMES=1, bytes 0x12,0x34,0x56 -> one cycle later oWRITE_EN=1, oWRITE_DATA=0x00123456, oWRITE_ADDR=0, oLoading=1.
REQ-033 iWRITE_FULL=1 for 5 cycles after the third byte -> oWRITE_EN stays 0 and oBYTE_READY stays 0; a single push occurs on the first cycle with iWRITE_FULL=0.
REQ-034 iNUM_FRAMES=2, full stream with FRAME_WORDS overridden to 4 -> addresses 0..7, oFrameIdx changes 0->1 after address 3, oDone pulses once after address 7, then oLoading=0.
REQ-035 iRST_n pulsed low after 2 bytes of a pixel -> all outputs 0; new iSTART plus 3 bytes -> pushes at address 0.
REQ-036 RGB565_EN defined, bytes 0xF8,0x1F -> oWRITE_DATA=0x00FF00FF.
REQ-037 iSTART reasserted during COLLECT, and iNUM_FRAMES=0 -> the reassertion is ignored and exactly one frame is loaded.
